// File: rtl/ro_stage_nway_pkg.sv
// Shared types for the N-lane read-operand stage: operand state, lane slot layout
// and the hard-wired zero register. Slot field widths follow the RO_* constants here.
package ro_stage_nway_pkg;

  localparam int RO_XLEN      = 32;
  localparam int RO_AW        = 5;
  localparam int RO_PAYLOAD_W = 160;

  localparam logic [RO_AW-1:0] REG_ZERO = '0;

  typedef enum logic {
    PEND = 1'b0,
    HELD = 1'b1
  } opnd_state_e;

  typedef struct packed {
    logic                    valid;
    logic                    bm;
    logic [RO_AW-1:0]        dest;
    logic [RO_AW-1:0]        src1;
    logic [RO_AW-1:0]        src2;
    logic                    src2_is_imm;
    logic [RO_PAYLOAD_W-1:0] payload;
    opnd_state_e             st1;
    opnd_state_e             st2;
    logic [RO_XLEN-1:0]      data1;
    logic [RO_XLEN-1:0]      data2;
  } lane_slot_t;

  function automatic logic is_zero_reg(input logic [RO_AW-1:0] addr);
    return addr == REG_ZERO;
  endfunction

endpackage

// File: rtl/ro_stage_nway_if.sv
// Bundle of ID, register-file, bypass and EX signals around the read-operand stage.
// The stage uses the slave view; the surrounding pipeline (or a bench) uses master.
interface ro_stage_nway_if #(
  parameter int LANES     = 2,
  parameter int NSRC      = 6,
  parameter int XLEN      = 32,
  parameter int AW        = 5,
  parameter int PAYLOAD_W = 160
);

  logic                         flush;
  logic                         ex_stall;

  logic [LANES-1:0]             id_valid;
  logic [LANES*AW-1:0]          id_src1;
  logic [LANES*AW-1:0]          id_src2;
  logic [LANES-1:0]             id_src2_is_imm;
  logic [LANES*XLEN-1:0]        id_imm;
  logic [LANES*AW-1:0]          id_dest;
  logic [LANES-1:0]             id_branch_mistaken;
  logic [LANES*PAYLOAD_W-1:0]   id_payload;
  logic                         ro_stall;

  logic [2*LANES*AW-1:0]        rf_addr;
  logic [2*LANES*XLEN-1:0]      rf_data;

  logic [NSRC-1:0]              byp_valid;
  logic [NSRC-1:0]              byp_forwardable;
  logic [NSRC*AW-1:0]           byp_dest;
  logic [NSRC*XLEN-1:0]         byp_result;

  logic [LANES-1:0]             ro_valid;
  logic [LANES*XLEN-1:0]        ro_src1;
  logic [LANES*XLEN-1:0]        ro_src2;
  logic [LANES*AW-1:0]          ro_dest;
  logic [LANES*PAYLOAD_W-1:0]   ro_payload;
  logic [LANES-1:0]             ro_branch_mistaken;

  modport master (
    output flush, ex_stall,
    output id_valid, id_src1, id_src2, id_src2_is_imm, id_imm, id_dest,
    output id_branch_mistaken, id_payload,
    input  ro_stall,
    input  rf_addr,
    output rf_data,
    output byp_valid, byp_forwardable, byp_dest, byp_result,
    input  ro_valid, ro_src1, ro_src2, ro_dest, ro_payload, ro_branch_mistaken
  );

  modport slave (
    input  flush, ex_stall,
    input  id_valid, id_src1, id_src2, id_src2_is_imm, id_imm, id_dest,
    input  id_branch_mistaken, id_payload,
    output ro_stall,
    output rf_addr,
    input  rf_data,
    input  byp_valid, byp_forwardable, byp_dest, byp_result,
    output ro_valid, ro_src1, ro_src2, ro_dest, ro_payload, ro_branch_mistaken
  );

endinterface

// File: rtl/ro_stage_nway_operand_resolver.sv
// Resolves one source address against the bypass sources (index 0 wins) with
// register-file data as fallback. Purely combinational.
module ro_operand_resolver
  import ro_stage_nway_pkg::*;
#(
  parameter int NSRC = 6,
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic [AW-1:0]        addr_i,
  input  logic [NSRC-1:0]      byp_valid_i,
  input  logic [NSRC-1:0]      byp_forwardable_i,
  input  logic [NSRC*AW-1:0]   byp_dest_i,
  input  logic [NSRC*XLEN-1:0] byp_result_i,
  input  logic [XLEN-1:0]      rf_data_i,
  output logic                 resolved_o,
  output logic [XLEN-1:0]      value_o
);

  // Walk from the oldest source down so the youngest match is the last one written.
  always_comb begin
    resolved_o = 1'b1;
    value_o    = rf_data_i;
    for (int k = NSRC - 1; k >= 0; k--) begin
      if (byp_valid_i[k] && (byp_dest_i[k*AW +: AW] == addr_i) &&
          (addr_i != AW'(REG_ZERO))) begin
        resolved_o = byp_forwardable_i[k];
        value_o    = byp_result_i[k*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/ro_stage_nway.sv
// N-lane read-operand stage: holds an issue group until every lane has both operands.
// Optional stall counters are enabled with the RO_STALL_CNT_EN macro.
module ro_stage_nway
  import ro_stage_nway_pkg::*;
#(
  parameter int LANES     = 2,
  parameter int NSRC      = 6,
  parameter int XLEN      = RO_XLEN,
  parameter int AW        = RO_AW,
  parameter int PAYLOAD_W = RO_PAYLOAD_W
) (
  input  logic          clk,
  input  logic          reset,
  ro_stage_nway_if.slave bus
`ifdef RO_STALL_CNT_EN
  ,
  output logic [31:0]   ro_hazard_cycles,
  output logic [31:0]   ro_ex_stall_cycles
`endif
);

  lane_slot_t       slot_q [LANES];
  lane_slot_t       slot_d [LANES];

  logic [LANES-1:0] res_ok1;
  logic [LANES-1:0] res_ok2;
  logic [XLEN-1:0]  res_val1 [LANES];
  logic [XLEN-1:0]  res_val2 [LANES];

  logic [LANES-1:0] rdy1;
  logic [LANES-1:0] rdy2;
  logic [LANES-1:0] lane_ready;
  logic [XLEN-1:0]  opnd1 [LANES];
  logic [XLEN-1:0]  opnd2 [LANES];

  logic             any_valid;
  logic             all_ready;
  logic             stall;
  logic [LANES-1:0] kill;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    ro_operand_resolver #(
      .NSRC (NSRC),
      .XLEN (XLEN),
      .AW   (AW)
    ) u_res1 (
      .addr_i            (slot_q[i].src1),
      .byp_valid_i       (bus.byp_valid),
      .byp_forwardable_i (bus.byp_forwardable),
      .byp_dest_i        (bus.byp_dest),
      .byp_result_i      (bus.byp_result),
      .rf_data_i         (bus.rf_data[(2*i)*XLEN +: XLEN]),
      .resolved_o        (res_ok1[i]),
      .value_o           (res_val1[i])
    );

    ro_operand_resolver #(
      .NSRC (NSRC),
      .XLEN (XLEN),
      .AW   (AW)
    ) u_res2 (
      .addr_i            (slot_q[i].src2),
      .byp_valid_i       (bus.byp_valid),
      .byp_forwardable_i (bus.byp_forwardable),
      .byp_dest_i        (bus.byp_dest),
      .byp_result_i      (bus.byp_result),
      .rf_data_i         (bus.rf_data[(2*i+1)*XLEN +: XLEN]),
      .resolved_o        (res_ok2[i]),
      .value_o           (res_val2[i])
    );
  end

  // HELD operands bypass the resolver entirely, so a stalled group never changes value.
  always_comb begin
    any_valid = 1'b0;
    all_ready = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      rdy1[i]       = (slot_q[i].st1 == HELD) || res_ok1[i];
      rdy2[i]       = (slot_q[i].st2 == HELD) || res_ok2[i];
      opnd1[i]      = (slot_q[i].st1 == HELD) ? slot_q[i].data1 : res_val1[i];
      opnd2[i]      = (slot_q[i].st2 == HELD) ? slot_q[i].data2 : res_val2[i];
      lane_ready[i] = !slot_q[i].valid || (rdy1[i] && rdy2[i]);
      any_valid     = any_valid | slot_q[i].valid;
      all_ready     = all_ready & lane_ready[i];
    end
    stall = any_valid && (!all_ready || bus.ex_stall);
  end

  always_comb begin
    bus.ro_stall           = stall;
    bus.rf_addr            = '0;
    bus.ro_valid           = '0;
    bus.ro_src1            = '0;
    bus.ro_src2            = '0;
    bus.ro_dest            = '0;
    bus.ro_payload         = '0;
    bus.ro_branch_mistaken = '0;
    for (int i = 0; i < LANES; i++) begin
      bus.rf_addr[(2*i)*AW +: AW]   = slot_q[i].src1;
      bus.rf_addr[(2*i+1)*AW +: AW] = slot_q[i].src2;
      bus.ro_valid[i]               = slot_q[i].valid;
      if (slot_q[i].valid) begin
        bus.ro_src1[i*XLEN +: XLEN]             = opnd1[i];
        bus.ro_src2[i*XLEN +: XLEN]             = opnd2[i];
        bus.ro_dest[i*AW +: AW]                 = slot_q[i].dest;
        bus.ro_payload[i*PAYLOAD_W +: PAYLOAD_W] = slot_q[i].payload;
      end
      bus.ro_branch_mistaken[i] = slot_q[i].bm && slot_q[i].valid && !stall;
    end
  end

  // A lane is killed when any older valid lane in the same group mispredicted.
  always_comb begin
    logic older_bm;
    older_bm = 1'b0;
    kill     = '0;
    for (int i = 0; i < LANES; i++) begin
      kill[i]  = older_bm;
      older_bm = older_bm | (bus.id_valid[i] & bus.id_branch_mistaken[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      slot_d[i] = slot_q[i];
    end
    if (bus.flush) begin
      for (int i = 0; i < LANES; i++) begin
        slot_d[i].valid = 1'b0;
      end
    end else if (!stall) begin
      for (int i = 0; i < LANES; i++) begin
        slot_d[i].valid       = bus.id_valid[i] && !kill[i];
        slot_d[i].bm          = bus.id_branch_mistaken[i];
        slot_d[i].dest        = bus.id_dest[i*AW +: AW];
        slot_d[i].src1        = bus.id_src1[i*AW +: AW];
        slot_d[i].src2        = bus.id_src2[i*AW +: AW];
        slot_d[i].src2_is_imm = bus.id_src2_is_imm[i];
        slot_d[i].payload     = bus.id_payload[i*PAYLOAD_W +: PAYLOAD_W];
        slot_d[i].st1         = is_zero_reg(bus.id_src1[i*AW +: AW]) ? HELD : PEND;
        slot_d[i].data1       = '0;
        slot_d[i].data2       = '0;
        if (bus.id_src2_is_imm[i]) begin
          slot_d[i].st2   = HELD;
          slot_d[i].data2 = bus.id_imm[i*XLEN +: XLEN];
        end else begin
          slot_d[i].st2   = is_zero_reg(bus.id_src2[i*AW +: AW]) ? HELD : PEND;
        end
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if ((slot_q[i].st1 == PEND) && res_ok1[i]) begin
          slot_d[i].st1   = HELD;
          slot_d[i].data1 = res_val1[i];
        end
        if ((slot_q[i].st2 == PEND) && res_ok2[i]) begin
          slot_d[i].st2   = HELD;
          slot_d[i].data2 = res_val2[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

`ifdef RO_STALL_CNT_EN
  // Saturating counters; a flush leaves them untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ro_hazard_cycles   <= '0;
      ro_ex_stall_cycles <= '0;
    end else begin
      if (any_valid && !all_ready && (ro_hazard_cycles != '1)) begin
        ro_hazard_cycles <= ro_hazard_cycles + 32'd1;
      end
      if (all_ready && bus.ex_stall && (ro_ex_stall_cycles != '1)) begin
        ro_ex_stall_cycles <= ro_ex_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ro_stage_nway.sv
// Self-checking bench for ro_stage_nway: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the operand-read rules.
module tb_ro_stage_nway;

  localparam int LANES = 2;
  localparam int NSRC  = 6;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int PW    = 160;

  logic clk;
  logic reset;

  ro_stage_nway_if #(
    .LANES(LANES), .NSRC(NSRC), .XLEN(XLEN), .AW(AW), .PAYLOAD_W(PW)
  ) bus ();

`ifdef RO_STALL_CNT_EN
  logic [31:0] hazCnt;
  logic [31:0] exCnt;
`endif

  ro_stage_nway #(
    .LANES(LANES), .NSRC(NSRC), .XLEN(XLEN), .AW(AW), .PAYLOAD_W(PW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef RO_STALL_CNT_EN
    ,
    .ro_hazard_cycles   (hazCnt),
    .ro_ex_stall_cycles (exCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference state: one entry per lane, two operands per lane.
  logic            mValid [LANES];
  logic            mBm    [LANES];
  logic [AW-1:0]   mDest  [LANES];
  logic [PW-1:0]   mPay   [LANES];
  logic [AW-1:0]   mAddr  [LANES][2];
  bit              mHeld  [LANES][2];
  logic [XLEN-1:0] mVal   [LANES][2];
  logic [XLEN-1:0] rf     [32];

  logic            expStall;
  bit              expOk  [LANES][2];
  logic [XLEN-1:0] expVal [LANES][2];

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < LANES; i++) begin
      mValid[i] = 1'b0;
      mBm[i]    = 1'b0;
      mDest[i]  = '0;
      mPay[i]   = '0;
      for (int o = 0; o < 2; o++) begin
        mAddr[i][o] = '0;
        mHeld[i][o] = 1'b0;
        mVal[i][o]  = '0;
      end
    end
  endtask

  task automatic clearInputs();
    bus.flush              = 1'b0;
    bus.ex_stall           = 1'b0;
    bus.id_valid           = '0;
    bus.id_src1            = '0;
    bus.id_src2            = '0;
    bus.id_src2_is_imm     = '0;
    bus.id_imm             = '0;
    bus.id_dest            = '0;
    bus.id_branch_mistaken = '0;
    bus.id_payload         = '0;
    bus.byp_valid          = '0;
    bus.byp_forwardable    = '0;
    bus.byp_dest           = '0;
    bus.byp_result         = '0;
  endtask

  task automatic setLane(input int i, input logic v, input logic [AW-1:0] s1,
                         input logic [AW-1:0] s2, input logic isImm,
                         input logic [XLEN-1:0] imm, input logic bm);
    bus.id_valid[i]               = v;
    bus.id_src1[i*AW +: AW]       = s1;
    bus.id_src2[i*AW +: AW]       = s2;
    bus.id_src2_is_imm[i]         = isImm;
    bus.id_imm[i*XLEN +: XLEN]    = imm;
    bus.id_dest[i*AW +: AW]       = AW'(i + 10);
    bus.id_branch_mistaken[i]     = bm;
    bus.id_payload[i*PW +: PW]    = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic setByp(input int k, input logic fwd, input logic [AW-1:0] d,
                        input logic [XLEN-1:0] r);
    bus.byp_valid[k]               = 1'b1;
    bus.byp_forwardable[k]         = fwd;
    bus.byp_dest[k*AW +: AW]       = d;
    bus.byp_result[k*XLEN +: XLEN] = r;
  endtask

  // The register file answers from the addresses the model believes are latched.
  task automatic driveRf();
    for (int i = 0; i < LANES; i++) begin
      for (int o = 0; o < 2; o++) begin
        bus.rf_data[(2*i+o)*XLEN +: XLEN] = rf[mAddr[i][o]];
      end
    end
  endtask

  task automatic settleInputs();
    driveRf();
    #1;
  endtask

  // First valid matching bypass wins; no match falls back to the register file.
  function automatic void resolveRef(input logic [AW-1:0] a, output bit ok,
                                     output logic [XLEN-1:0] v);
    bit found;
    found = 1'b0;
    ok    = 1'b1;
    v     = rf[a];
    if (a != '0) begin
      for (int k = 0; k < NSRC; k++) begin
        if (!found && bus.byp_valid[k] && (bus.byp_dest[k*AW +: AW] == a)) begin
          found = 1'b1;
          ok    = bus.byp_forwardable[k];
          v     = bus.byp_result[k*XLEN +: XLEN];
        end
      end
    end
  endfunction

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic applyStimulus();
    bit              anyV;
    bit              allR;
    bit              killed;
    logic [LANES-1:0] ev;
    driveRf();
    @(negedge clk);
    anyV = 1'b0;
    allR = 1'b1;
    ev   = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int o = 0; o < 2; o++) begin
        if (mHeld[i][o]) begin
          expOk[i][o]  = 1'b1;
          expVal[i][o] = mVal[i][o];
        end else begin
          resolveRef(mAddr[i][o], expOk[i][o], expVal[i][o]);
        end
      end
      ev[i] = mValid[i];
      if (mValid[i]) begin
        anyV = 1'b1;
        if (!(expOk[i][0] && expOk[i][1])) allR = 1'b0;
      end
    end
    expStall = anyV && (!allR || bus.ex_stall);
    checkOutput("ro_stall", bus.ro_stall, expStall);
    checkOutput("ro_valid", bus.ro_valid, ev);
    for (int i = 0; i < LANES; i++) begin
      checkOutput($sformatf("ro_src1[%0d]", i), bus.ro_src1[i*XLEN +: XLEN],
                  mValid[i] ? expVal[i][0] : '0);
      checkOutput($sformatf("ro_src2[%0d]", i), bus.ro_src2[i*XLEN +: XLEN],
                  mValid[i] ? expVal[i][1] : '0);
      checkOutput($sformatf("ro_dest[%0d]", i), bus.ro_dest[i*AW +: AW],
                  mValid[i] ? mDest[i] : '0);
      checkOutput($sformatf("ro_payload[%0d]", i), bus.ro_payload[i*PW +: PW],
                  mValid[i] ? mPay[i] : '0);
      checkOutput($sformatf("ro_bm[%0d]", i), bus.ro_branch_mistaken[i],
                  mValid[i] && mBm[i] && !expStall);
      checkOutput($sformatf("rf_addr[%0d]", 2*i), bus.rf_addr[(2*i)*AW +: AW], mAddr[i][0]);
      checkOutput($sformatf("rf_addr[%0d]", 2*i+1), bus.rf_addr[(2*i+1)*AW +: AW], mAddr[i][1]);
    end
    @(posedge clk);
    if (bus.flush) begin
      for (int i = 0; i < LANES; i++) mValid[i] = 1'b0;
    end else if (!expStall) begin
      killed = 1'b0;
      for (int i = 0; i < LANES; i++) begin
        mValid[i]   = bus.id_valid[i] && !killed;
        killed      = killed || (bus.id_valid[i] && bus.id_branch_mistaken[i]);
        mBm[i]      = bus.id_branch_mistaken[i];
        mDest[i]    = bus.id_dest[i*AW +: AW];
        mPay[i]     = bus.id_payload[i*PW +: PW];
        mAddr[i][0] = bus.id_src1[i*AW +: AW];
        mAddr[i][1] = bus.id_src2[i*AW +: AW];
        mHeld[i][0] = (mAddr[i][0] == '0);
        mVal[i][0]  = '0;
        if (bus.id_src2_is_imm[i]) begin
          mHeld[i][1] = 1'b1;
          mVal[i][1]  = bus.id_imm[i*XLEN +: XLEN];
        end else begin
          mHeld[i][1] = (mAddr[i][1] == '0);
          mVal[i][1]  = '0;
        end
      end
    end else begin
      for (int i = 0; i < LANES; i++) begin
        for (int o = 0; o < 2; o++) begin
          if (!mHeld[i][o] && expOk[i][o]) begin
            mHeld[i][o] = 1'b1;
            mVal[i][o]  = expVal[i][o];
          end
        end
      end
    end
    #1;
  endtask

  initial begin
`ifdef RO_STALL_CNT_EN
    logic [31:0] hazBefore;
`endif
    reset = 1'b0;
    clearInputs();
    modelReset();
    for (int a = 0; a < 32; a++) rf[a] = $urandom;
    rf[0] = '0;
    driveRf();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset ro_valid", bus.ro_valid, '0);
    checkOutput("reset ro_stall", bus.ro_stall, 1'b0);
    checkOutput("reset ro_bm", bus.ro_branch_mistaken, '0);
    checkOutput("reset rf_addr", bus.rf_addr, '0);
    reset = 1'b1;

    // RF read with no bypass match.
    rf[3] = 32'h11;
    setLane(0, 1'b1, 5'd3, 5'd0, 1'b1, 32'h1234, 1'b0);
    applyStimulus();
    clearInputs();
    settleInputs();
    checkOutput("tp1 src1", bus.ro_src1[XLEN-1:0], 32'h11);
    checkOutput("tp1 stall", bus.ro_stall, 1'b0);
    applyStimulus();

    // Bypass priority: youngest matching source wins.
    setLane(0, 1'b1, 5'd3, 5'd0, 1'b1, 32'h0, 1'b0);
    applyStimulus();
    clearInputs();
    setByp(0, 1'b1, 5'd3, 32'hAA);
    setByp(3, 1'b1, 5'd3, 32'hBB);
    settleInputs();
    checkOutput("tp2 byp0", bus.ro_src1[XLEN-1:0], 32'hAA);
    applyStimulus();
    setLane(0, 1'b1, 5'd3, 5'd0, 1'b1, 32'h0, 1'b0);
    applyStimulus();
    clearInputs();
    setByp(3, 1'b1, 5'd3, 32'hBB);
    settleInputs();
    checkOutput("tp2 byp3", bus.ro_src1[XLEN-1:0], 32'hBB);
    applyStimulus();

    // Load-use: two unresolved cycles, then forwarded.
    clearInputs();
    setLane(1, 1'b1, 5'd0, 5'd5, 1'b0, 32'h0, 1'b0);
    applyStimulus();
`ifdef RO_STALL_CNT_EN
    hazBefore = hazCnt;
`endif
    clearInputs();
    setByp(1, 1'b0, 5'd5, 32'hDEAD);
    for (int c = 0; c < 2; c++) begin
      settleInputs();
      checkOutput($sformatf("tp3 stall c%0d", c), bus.ro_stall, 1'b1);
      applyStimulus();
    end
    setByp(1, 1'b1, 5'd5, 32'h5);
    settleInputs();
    checkOutput("tp3 src2", bus.ro_src2[2*XLEN-1:XLEN], 32'h5);
    checkOutput("tp3 release", bus.ro_stall, 1'b0);
    applyStimulus();
`ifdef RO_STALL_CNT_EN
    checkOutput("tp6 hazard cnt", hazCnt - hazBefore, 32'd2);
`endif

    // A resolved operand stays latched across bypass changes while EX stalls.
    clearInputs();
    setLane(0, 1'b1, 5'd7, 5'd0, 1'b1, 32'h0, 1'b0);
    applyStimulus();
    clearInputs();
    bus.ex_stall = 1'b1;
    setByp(2, 1'b1, 5'd7, 32'h7);
    repeat (3) applyStimulus();
    bus.ex_stall = 1'b0;
    setByp(2, 1'b1, 5'd7, 32'h9);
    settleInputs();
    checkOutput("tp4 held", bus.ro_src1[XLEN-1:0], 32'h7);
    applyStimulus();

    // Mispredict kills the younger lane; the flag only shows when not stalled.
    clearInputs();
    setLane(0, 1'b1, 5'd0, 5'd0, 1'b1, 32'h1, 1'b1);
    setLane(1, 1'b1, 5'd0, 5'd0, 1'b1, 32'h2, 1'b0);
    applyStimulus();
    clearInputs();
    bus.ex_stall = 1'b1;
    settleInputs();
    checkOutput("tp5 kill", bus.ro_valid, 2'b01);
    checkOutput("tp5 bm stalled", bus.ro_branch_mistaken, 2'b00);
    applyStimulus();
    bus.ex_stall = 1'b0;
    settleInputs();
    checkOutput("tp5 bm free", bus.ro_branch_mistaken, 2'b01);
    applyStimulus();

    // Flush while stalled clears the group.
    setLane(0, 1'b1, 5'd0, 5'd0, 1'b1, 32'h3, 1'b0);
    setLane(1, 1'b1, 5'd0, 5'd0, 1'b1, 32'h4, 1'b0);
    applyStimulus();
    clearInputs();
    bus.ex_stall = 1'b1;
    bus.flush    = 1'b1;
    applyStimulus();
    bus.flush = 1'b0;
    settleInputs();
    checkOutput("tp5 flush", bus.ro_valid, 2'b00);
    applyStimulus();

    // Asynchronous reset in the middle of a stall, between clock edges.
    clearInputs();
    setLane(0, 1'b1, 5'd0, 5'd0, 1'b1, 32'h5, 1'b0);
    applyStimulus();
    clearInputs();
    bus.ex_stall = 1'b1;
    applyStimulus();
    reset = 1'b0;
    #1;
    checkOutput("tp6 async valid", bus.ro_valid, 2'b00);
    checkOutput("tp6 async stall", bus.ro_stall, 1'b0);
    modelReset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    clearInputs();

    // Randomized traffic over a small register window to force collisions.
    for (int c = 0; c < 400; c++) begin
      clearInputs();
      for (int i = 0; i < LANES; i++) begin
        setLane(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                AW'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0), $urandom,
                ($urandom_range(0, 6) == 0));
      end
      for (int k = 0; k < NSRC; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          setByp(k, ($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), $urandom);
        end
      end
      bus.ex_stall = ($urandom_range(0, 9) < 3);
      bus.flush    = ($urandom_range(0, 19) == 0);
      rf[$urandom_range(1, 7)] = $urandom;
      applyStimulus();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ro_stage_nway.md
Name: ro_stage_nway

Overview:
- Parametrised N-lane read-operand stage between decode (ID) and execute (EX).
- Latches a decoded issue group and resolves each lane's two source operands from the register file or from NSRC bypass sources.
- Holds the group until every valid lane has both operands, then releases it to EX atomically.
- Unlike the fixed dual-lane stage, captured operands are latched once resolved, so later bypass changes cannot corrupt a stalled group.

Parameters:
LANES, 2, issue lanes per group (1..4)
NSRC, 6, bypass sources; index 0 = youngest producer, highest priority
XLEN, 32, data width
AW, 5, register address width
PAYLOAD_W, 160, opaque decoded fields carried unchanged (opcode, mem, csr, branch info)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low (0 = reset)
flush  in  1  discard all held and incoming lanes
ex_stall  in  1  EX cannot accept
id_valid  in  LANES  lane valid from ID
id_src1  in  LANES*AW  source-1 register address
id_src2  in  LANES*AW  source-2 register address
id_src2_is_imm  in  LANES  source 2 is the immediate
id_imm  in  LANES*XLEN  immediate value
id_dest  in  LANES*AW  destination register
id_branch_mistaken  in  LANES  lane detected a mispredict
id_payload  in  LANES*PAYLOAD_W  opaque decoded fields
ro_stall  out  1  ID must hold its group
rf_addr  out  2*LANES*AW  register-file read addresses; lane i src1 at slot 2i, src2 at slot 2i+1
rf_data  in  2*LANES*XLEN  register-file read data, same slot order
byp_valid  in  NSRC  bypass source holds a valid instruction
byp_forwardable  in  NSRC  bypass result is available
byp_dest  in  NSRC*AW  bypass destination
byp_result  in  NSRC*XLEN  bypass result
ro_valid  out  LANES  lane valid toward EX
ro_src1  out  LANES*XLEN  resolved operand 1
ro_src2  out  LANES*XLEN  resolved operand 2
ro_dest  out  LANES*AW  destination register
ro_payload  out  LANES*PAYLOAD_W  payload
ro_branch_mistaken  out  LANES  mispredict, qualified by !ro_stall

Behaviour:
- Reset (async, while reset==0):
  - all slot valid bits 0
  - all operand states PEND, latched operand data 0
  - all outputs 0, including ro_stall and ro_branch_mistaken
- Accept: on clk edge when !ro_stall, slot[i] <= ID lane i.
  - slot valid = id_valid[i] && !(any j<i with id_valid[j] && id_branch_mistaken[j]).
  - Younger lanes behind a mispredict are killed.
- Flush: clears all slot valid bits at the next edge and overrides accept.
- Operand state per source, PEND or HELD:
  - On accept, src2 with src2_is_imm goes HELD with value imm.
  - Any source with address 0 goes HELD with value 0.
  - All other sources go PEND.
- PEND resolution (combinational each cycle): scan bypass sources from index 0 upward; first k with byp_valid[k] && byp_dest[k]==addr && addr!=0.
  - byp_forwardable[k]: resolved, value byp_result[k].
  - not forwardable: unresolved (load-use / multicycle producer).
  - no match: resolved, value rf_data.
- rf_addr is driven from the slot's latched addresses every cycle; the RF is re-read while PEND.
- Zero extra latency: a resolved PEND operand drives ro_src* combinationally in the same cycle.
- If the slot does not leave that cycle, a resolved PEND operand is latched and goes HELD.
- HELD output = latched value; it is never re-resolved.
- ready_i = !slot_valid[i] || both operands resolved or HELD.
- ro_stall = (any slot valid) && (!(all ready_i) || ex_stall).
- The group leaves only as a whole: no partial issue.
- ro_valid[i] = slot_valid[i].
- ro_branch_mistaken[i] = slot_bm[i] && slot_valid[i] && !ro_stall.
- Simultaneous events:
  - flush with stall: cleared.
  - Empty slots with ex_stall: ro_stall=0, so bubbles are replaced.
  - Reset mid-stall: group lost, no output.
- Intra-group RAW is not resolved here; ID never issues dependent lanes together.

Optional Feature:
- Macro RO_STALL_CNT_EN.
- When defined, adds two 32-bit saturating output counters:
  - ro_hazard_cycles: cycles with any slot valid and !all ready.
  - ro_ex_stall_cycles: cycles with all ready && ex_stall.
- Counters reset to 0 on reset; flush does not clear them.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - operand state enum (PEND, HELD)
  - lane slot struct (valid, bm, dest, src addrs, imm flags, payload, per-operand state and data)
  - localparam REG_ZERO = 0
- One natural sub-module, ro_operand_resolver: one address → resolved/value against NSRC bypasses plus RF data.
  - Instantiated 2*LANES times.
  - Purely combinational; all sequencing stays in the top.

Test Plan:
1. LANES=2, reset released, lane0 src1=r3, rf_data=0x11, no bypass match → next cycle ro_src1[0]=0x11, ro_stall=0.
2. Bypass priority: byp0 dest r3 =0xAA forwardable, byp3 dest r3 =0xBB → ro_src1=0xAA; only byp3 matching → 0xBB.
3. Load-use: byp1 dest r5 valid, not forwardable for 2 cycles, lane1 src2=r5 → ro_stall=1 for 2 cycles; third cycle forwardable 0x5 → ro_src2[1]=0x5, group leaves.
4. HELD latching: operand resolved to 0x7 while ex_stall=1 for 3 cycles, bypass then changes to 0x9 → output stays 0x7 at issue.
5. Mispredict kill: id_valid=11, id_branch_mistaken=01 → only ro_valid[0]=1; ro_branch_mistaken[0]=1 only in the non-stalled cycle. Flush during a stall → ro_valid=00 next cycle.
6. Async reset asserted mid-stall, no clock edge → ro_valid=0 and ro_stall=0 immediately. With RO_STALL_CNT_EN defined, hazard counter counts 2 in scenario 3.
